// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one word-aligned bus access per instruction,
// byte/half lane steering, load extension and a no-ack watchdog.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] rd_data_o,
   output logic        busywait_o,
   output logic        misaligned_o,
   output logic        bus_err_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_wstrb_o,
   input  logic [31:0] dmem_rdata_i,
   input  logic        dmem_ack_i
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [1:0]    off;
   logic          is_b;
   logic          is_h;
   logic          mis_cond;
   logic          acc;
   logic          launch;
   logic          expire;
   logic [CW-1:0] cnt;
   logic [3:0]    strb;
   logic [31:0]   wdata;
   logic [1:0]    q_off;
   logic          q_b;
   logic          q_h;
   logic          q_uns;
   logic          q_rd;
   logic          err_q;
   logic [15:0]   lane;
   logic [31:0]   ext;

   assign off          = addr_i[1:0];
   assign is_b         = funct3_i[1:0] == 2'b00;
   assign is_h         = funct3_i[1:0] == 2'b01;
   assign mis_cond     = (is_h & off[0]) | (~is_b & ~is_h & (off != 2'b00));
   assign misaligned_o = (mem_read_i | mem_write_i) & mis_cond;
   assign acc          = (mem_read_i | mem_write_i) & ~mis_cond;
   assign launch       = (state == IDLE) & acc;
   assign expire       = (state == BUSY) & ~dmem_ack_i & (cnt == LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (acc) state_nxt = BUSY;
         BUSY:    if (dmem_ack_i || expire) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stall is masked during reset so the pipeline sees a quiet unit.
   always_comb begin
      busywait_o = rst_ni & (launch | (state == BUSY));
      dmem_req_o = state == BUSY;
      bus_err_o  = err_q;
   end

   always_comb begin
      strb  = 4'b1111;
      wdata = store_data_i;
      if (is_b) begin
         strb  = 4'b0001 << off;
         wdata = {4{store_data_i[7:0]}};
      end else if (is_h) begin
         strb  = 4'b0011 << off;
         wdata = {2{store_data_i[15:0]}};
      end
      if (!mem_write_i) strb = 4'b0000;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dmem_addr_o  <= '0;
         dmem_we_o    <= 1'b0;
         dmem_wstrb_o <= '0;
         dmem_wdata_o <= '0;
         q_off        <= '0;
         q_b          <= 1'b0;
         q_h          <= 1'b0;
         q_uns        <= 1'b0;
         q_rd         <= 1'b0;
      end else if (launch) begin
         dmem_addr_o  <= {addr_i[31:2], 2'b00};
         dmem_we_o    <= mem_write_i;
         dmem_wstrb_o <= strb;
         dmem_wdata_o <= wdata;
         q_off        <= off;
         q_b          <= is_b;
         q_h          <= is_h;
         q_uns        <= funct3_i[2];
         q_rd         <= mem_read_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= expire;
         if (launch)
            cnt <= '0;
         else if (state == BUSY && !dmem_ack_i)
            cnt <= cnt + CW'(1);
      end
   end

   assign lane = 16'(dmem_rdata_i >> {q_off, 3'b000});

   always_comb begin
      ext = dmem_rdata_i;
      if (q_b)
         ext = {{24{~q_uns & lane[7]}}, lane[7:0]};
      else if (q_h)
         ext = {{16{~q_uns & lane[15]}}, lane[15:0]};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         rd_data_o <= '0;
      else if (state == BUSY && dmem_ack_i && q_rd)
         rd_data_o <= ext;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: transaction-level model checked
// every cycle, plus literal expectations from hand calculation.
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [31:0] rd_data;
   logic        busywait;
   logic        misaligned;
   logic        bus_err;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .mem_read_i   (mem_read),
      .mem_write_i  (mem_write),
      .funct3_i     (funct3),
      .addr_i       (addr),
      .store_data_i (store_data),
      .rd_data_o    (rd_data),
      .busywait_o   (busywait),
      .misaligned_o (misaligned),
      .bus_err_o    (bus_err),
      .dmem_req_o   (dmem_req),
      .dmem_we_o    (dmem_we),
      .dmem_addr_o  (dmem_addr),
      .dmem_wdata_o (dmem_wdata),
      .dmem_wstrb_o (dmem_wstrb),
      .dmem_rdata_i (dmem_rdata),
      .dmem_ack_i   (dmem_ack)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 0;

   logic        exp_busy = 0;
   logic        exp_req = 0;
   logic        exp_mis = 0;
   logic        exp_err = 0;
   logic        exp_we = 0;
   logic [31:0] exp_rd = 0;
   logic [31:0] exp_addr = 0;
   logic [31:0] exp_wdata = 0;
   logic [3:0]  exp_strb = 0;

   int busy_cnt = 0;
   int req_cnt = 0;
   int err_cnt = 0;
   int mis_cnt = 0;
   logic [31:0] last_addr = 0;
   logic [31:0] last_wdata = 0;
   logic [3:0]  last_strb = 0;
   logic        last_we = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] load_val(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] w);
      int unsigned sh;
      int unsigned v;
      sh = w >> (8 * (a % 4));
      case (f3)
         3'b000: begin
            v = sh & 32'hFF;
            if (v >= 128) v = v + 32'hFFFFFF00;
         end
         3'b100: v = sh & 32'hFF;
         3'b001: begin
            v = sh & 32'hFFFF;
            if (v >= 32768) v = v + 32'hFFFF0000;
         end
         3'b101: v = sh & 32'hFFFF;
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic int size_of(input logic [2:0] f3);
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   always @(negedge clk) begin
      if (busywait) busy_cnt++;
      if (bus_err) err_cnt++;
      if (misaligned) mis_cnt++;
      if (dmem_req) begin
         req_cnt++;
         last_addr = dmem_addr;
         last_wdata = dmem_wdata;
         last_strb = dmem_wstrb;
         last_we = dmem_we;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busywait", busywait, exp_busy);
         chk("req", dmem_req, exp_req);
         chk("misaligned", misaligned, exp_mis);
         chk("bus_err", bus_err, exp_err);
         chk("rd_data", rd_data, exp_rd);
         if (exp_req) begin
            chk("addr", dmem_addr, exp_addr);
            chk("we", dmem_we, exp_we);
            chk("wstrb", dmem_wstrb, exp_strb);
            if (exp_we) chk("wdata", dmem_wdata, exp_wdata);
         end
      end
   end

   // Called one time unit after a rising edge; ack_at=0 means never ack.
   task automatic do_access(input bit rd, input bit wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] rw,
                            input int ack_at);
      int sz;
      bit acked;
      bit mis;
      sz = size_of(f3);
      mis = (a % sz) != 0;
      mem_read = rd;
      mem_write = wr;
      funct3 = f3;
      addr = a;
      store_data = sd;
      dmem_ack = 0;
      exp_mis = mis;
      exp_busy = !mis;
      exp_req = 0;
      exp_err = 0;
      @(posedge clk);
      #1;
      if (mis) begin
         mem_read = 0;
         mem_write = 0;
         exp_mis = 0;
         exp_busy = 0;
         return;
      end
      exp_req = 1;
      exp_addr = a - (a % 4);
      exp_we = wr;
      exp_strb = 0;
      if (wr) begin
         if (sz == 1) begin
            exp_strb = 4'(1 << (a % 4));
            exp_wdata = (sd & 32'hFF) * 32'h01010101;
         end else if (sz == 2) begin
            exp_strb = 4'(3 << (a % 4));
            exp_wdata = (sd & 32'hFFFF) * 32'h00010001;
         end else begin
            exp_strb = 4'hF;
            exp_wdata = sd;
         end
      end
      acked = 0;
      for (int i = 1; i <= TO; i++) begin
         dmem_ack = (i == ack_at);
         dmem_rdata = dmem_ack ? rw : (32'h5A0F_3C00 ^ i);
         @(posedge clk);
         #1;
         if (i == ack_at) begin
            acked = 1;
            break;
         end
      end
      dmem_ack = 0;
      exp_req = 0;
      exp_busy = 0;
      exp_err = !acked;
      if (acked && rd) exp_rd = load_val(f3, a, rw);
      @(posedge clk);
      #1;
      exp_err = 0;
      exp_mis = 0;
      mem_read = 0;
      mem_write = 0;
   endtask

   task automatic do_idle(input bit ack);
      mem_read = 0;
      mem_write = 0;
      dmem_ack = ack;
      dmem_rdata = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      dmem_ack = 0;
   endtask

   initial begin
      rst_n = 0;
      mem_read = 1;
      mem_write = 0;
      funct3 = 3'b010;
      addr = 32'h1000;
      store_data = 0;
      dmem_rdata = 0;
      dmem_ack = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd", rd_data, 0);
      chk("rst_busy", busywait, 0);
      chk("rst_err", bus_err, 0);
      chk("rst_req", dmem_req, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_wstrb", dmem_wstrb, 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_wdata", dmem_wdata, 0);
      rst_n = 1;
      #1;
      chk("release_busy", busywait, 1);
      chk("release_req", dmem_req, 0);
      chk_en = 1;
      do_access(1, 0, 3'b010, 32'h1000, 0, 32'h1111_1111, 1);
      chk("lw_first", rd_data, 32'h1111_1111);

      busy_cnt = 0;
      do_access(1, 0, 3'b000, 32'h1003, 0, 32'h80AA_55CC, 3);
      chk("lb_busy_cycles", busy_cnt, 4);
      chk("lb_addr", last_addr, 32'h1000);
      chk("lb_val", rd_data, 32'hFFFF_FF80);
      do_access(1, 0, 3'b100, 32'h1003, 0, 32'h80AA_55CC, 3);
      chk("lbu_val", rd_data, 32'h0000_0080);

      do_access(0, 1, 3'b001, 32'h2002, 32'h1234_BEEF, 0, 1);
      chk("sh_wstrb", last_strb, 4'b1100);
      chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);
      chk("sh_we", last_we, 1);
      chk("sh_rd_keep", rd_data, 32'h0000_0080);

      do_access(1, 0, 3'b001, 32'h5002, 0, 32'h8001_0000, 1);
      chk("lh_val", rd_data, 32'hFFFF_8001);
      do_access(1, 0, 3'b101, 32'h5000, 0, 32'h1234_ABCD, 2);
      chk("lhu_val", rd_data, 32'h0000_ABCD);
      do_access(0, 1, 3'b000, 32'h6001, 32'h0000_00A5, 0, 1);
      chk("sb_wstrb", last_strb, 4'b0010);
      chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);

      req_cnt = 0;
      mis_cnt = 0;
      do_access(1, 0, 3'b010, 32'h3001, 0, 0, 1);
      do_access(0, 1, 3'b001, 32'h2003, 32'h1, 0, 1);
      do_idle(0);
      chk("mis_req_cnt", req_cnt, 0);
      chk("mis_cnt", mis_cnt, 2);
      do_idle(1);
      chk("stray_ack_rd", rd_data, 32'h0000_ABCD);

      req_cnt = 0;
      err_cnt = 0;
      do_access(1, 0, 3'b010, 32'h4000, 0, 32'h1122_3344, 0);
      chk("to_req_cycles", req_cnt, TO);
      chk("to_err_pulses", err_cnt, 1);
      chk("to_rd_keep", rd_data, 32'h0000_ABCD);
      err_cnt = 0;
      do_access(1, 0, 3'b010, 32'h4000, 0, 32'h1122_3344, TO);
      chk("late_ack_no_err", err_cnt, 0);
      chk("late_ack_rd", rd_data, 32'h1122_3344);

      do_access(1, 0, 3'b010, 32'h7000, 0, 32'hDEAD_BEEF, 1);
      chk("b2b_lw", rd_data, 32'hDEAD_BEEF);
      do_access(0, 1, 3'b010, 32'h7004, 32'hCAFE_F00D, 0, 1);
      chk("b2b_sw_wdata", last_wdata, 32'hCAFE_F00D);
      chk("b2b_sw_strb", last_strb, 4'hF);
      chk("b2b_sw_rd", rd_data, 32'hDEAD_BEEF);

      chk_en = 0;
      mem_read = 1;
      funct3 = 3'b010;
      addr = 32'h8000;
      @(posedge clk);
      #1;
      chk("mid_busy_req", dmem_req, 1);
      #2;
      rst_n = 0;
      #1;
      chk("async_rst_req", dmem_req, 0);
      chk("async_rst_busy", busywait, 0);
      mem_read = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      do_idle(1);
      chk("post_rst_req", dmem_req, 0);
      chk("post_rst_rd", rd_data, 0);
      chk("post_rst_busy", busywait, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data access unit between the EX/MEM pipeline register and the MEM/WB register. It converts a load/store from the execute stage into a single word-aligned request on the data-memory bus, with byte/half/word lane handling and load sign/zero extension. While an access is outstanding it asserts `busywait_o` to freeze the pipeline registers, including the MEM/WB register's `busywait` input. It delivers load data to the MEM/WB register's `rd_data` input.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum `BUSY` cycles before a missing `dmem_ack_i` is declared a bus error. Must be ≥1; it sets the watchdog counter width.
- `clk_i` input 1: clock; all state changes on the rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `mem_read_i` input 1: the instruction in MEM is a load.
- `mem_write_i` input 1: the instruction in MEM is a store. Never high together with `mem_read_i`.
- `funct3_i` input 3: size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are treated as W.
- `addr_i` input 32: byte address (ALU result).
- `store_data_i` input 32: rs2 value.
- `rd_data_o` output 32: extended load result, registered.
- `busywait_o` output 1: pipeline stall request.
- `misaligned_o` output 1: combinational; the current access is misaligned and is suppressed.
- `bus_err_o` output 1: one-cycle pulse when the watchdog expires.
- `dmem_req_o` output 1: bus request.
- `dmem_we_o` output 1: 1 = write.
- `dmem_addr_o` output 32: `{addr_i[31:2],2'b00}`.
- `dmem_wdata_o` output 32: lane-replicated store data.
- `dmem_wstrb_o` output 4: byte enables; 0 for reads.
- `dmem_rdata_i` input 32: read word, valid in the cycle `dmem_ack_i` is high.
- `dmem_ack_i` input 1: single-cycle completion strobe.

## Operation
- Access request `acc = (mem_read_i | mem_write_i) & ~misaligned_o`.
- Misaligned conditions:
  - H/HU when `addr_i[0]` = 1.
  - W when `addr_i[1:0]` ≠ 0.
  - Byte accesses are never misaligned.
  - A misaligned access produces no bus activity, `busywait_o` = 0, and leaves `rd_data_o` unchanged.
- FSM states: `IDLE`, `BUSY`, `DONE`.
  - `IDLE` → `BUSY` when `acc`.
  - `BUSY` → `DONE` on `dmem_ack_i`, or on watchdog expiry.
  - `DONE` → `IDLE` unconditionally.
- `busywait_o` = (`IDLE` & `acc`) | `BUSY`. It is low in `DONE`, so the pipeline advances at the end of `DONE`.
- `dmem_req_o` is high only in `BUSY`. `dmem_addr_o`, `dmem_we_o`, `dmem_wdata_o` and `dmem_wstrb_o` are stable throughout `BUSY`; the inputs are frozen by the stall.
- Store lanes, with `o = addr_i[1:0]`:
  - SB: wstrb = `4'b0001<<o`, wdata = byte ×4.
  - SH: wstrb = `4'b0011<<o`, wdata = half ×2.
  - SW: wstrb = `4'b1111`, wdata = data.
- Load extract on ack:
  - B/BU: `rdata[8*o +: 8]`, sign- or zero-extended.
  - H/HU: `rdata[8*o +: 16]`, extended.
  - W: full word.
  - The result is captured into `rd_data_o` on the ack edge and held until the next load ack.
- Stores never modify `rd_data_o`.
- Watchdog: the counter clears on entering `BUSY` and increments each `BUSY` cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES`: go to `DONE`, pulse `bus_err_o` in the `DONE` cycle, and leave `rd_data_o` unchanged.
  - An ack arriving in the expiry cycle wins: normal completion, no error.
- `dmem_ack_i` outside `BUSY` is ignored.

## Timing
- Reset values:
  - `rd_data_o` = 0, `busywait_o` = 0, `bus_err_o` = 0, `dmem_req_o` = 0, `dmem_we_o` = 0, `dmem_wstrb_o` = 0.
  - `dmem_addr_o` and `dmem_wdata_o` = 0.
  - FSM = `IDLE`, counter = 0.
- Reset asserted mid-access drops `dmem_req_o` immediately (asynchronous). A late ack after reset is ignored.
- Latency: with ack in the first `BUSY` cycle, an access occupies 3 cycles (`IDLE`, `BUSY`, `DONE`). Each extra wait cycle adds 1.
- `rd_data_o` is valid from the `DONE` cycle; MEM/WB samples it at the end of `DONE`.
- Back-to-back accesses: the next instruction is present in `IDLE` after `DONE`, with no bubble beyond the 3-cycle minimum.

## Test plan
- Reset: `rst_ni`=0 with `mem_read_i`=1 → all outputs 0 and no request. Release → `busywait_o`=1 in the same cycle, `dmem_req_o`=1 next cycle.
- LB: `addr_i`=0x1003, rdata=0x80AA55CC, ack after 2 wait cycles → `dmem_addr_o`=0x1000, `busywait_o` high 4 cycles, `rd_data_o`=0xFFFFFF80. Repeat as LBU → 0x00000080.
- SH: `addr_i`=0x2002, `store_data_i`=0x1234BEEF → `dmem_wstrb_o`=4'b1100, `dmem_wdata_o`=0xBEEFBEEF, `dmem_we_o`=1, `rd_data_o` unchanged.
- LW to 0x3001 → `misaligned_o`=1, `busywait_o`=0, `dmem_req_o` never asserted.
- `TIMEOUT_CYCLES`=4, no ack → `dmem_req_o` high 4 cycles, then `bus_err_o` 1-cycle pulse, `busywait_o` drops. Repeat with ack on the 4th cycle → no error.
- LW ack=0xDEADBEEF followed by SW back-to-back → `rd_data_o`=0xDEADBEEF after the first access; the second access starts in the cycle after `DONE`. Assert `rst_ni` low mid-`BUSY` → `dmem_req_o` drops asynchronously.
